// File: rtl/f_add_sub_mult.sv
// f_add_sub_mult: fully pipelined binary64 add / subtract / multiply, operation fixed by OP.
// Define F_ARITH_OUT_REG_EN to add one output register stage (latency becomes LATENCY+1).
module f_add_sub_mult #(
    parameter int FLEN    = 64,
    parameter int OP      = 0,
    parameter int LATENCY = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    input  logic            up_valid,
    output logic [FLEN-1:0] res,
    output logic            down_valid,
    output logic            busy,
    output logic            error
);

`ifdef F_ARITH_OUT_REG_EN
    localparam int STAGES = LATENCY + 1;
`else
    localparam int STAGES = LATENCY;
`endif

    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    typedef struct packed {
        logic        err;
        logic [63:0] val;
    } result_t;

    function automatic result_t mk(input logic err, input logic [63:0] val);
        result_t r;
        r.err = err;
        r.val = val;
        return r;
    endfunction

    function automatic logic is_nan(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
    endfunction

    function automatic logic [5:0] clz56(input logic [55:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < 56; i++)
            if (v[i]) c = 6'(55 - i);
        return c;
    endfunction

    // n holds a normalised significand (bit 55 = hidden 1) followed by guard, round, sticky.
    // A carry out of the fraction leaves it all-zero, which is exactly 1.0 at exponent+1.
    function automatic result_t round_pack(input logic s, input logic signed [13:0] e,
                                           input logic [55:0] n);
        logic               up;
        logic [52:0]        f;
        logic signed [13:0] ee;
        up = n[2] & (n[1] | n[0] | n[3]);
        f  = {1'b0, n[54:3]} + {52'd0, up};
        ee = f[52] ? e + 14'sd1 : e;
        if (ee >= 14'sd2047) return mk(1'b1, {s, 11'h7FF, 52'd0});
        if (ee <= 14'sd0)    return mk(1'b0, {s, 63'd0});
        return mk(1'b0, {s, ee[10:0], f[51:0]});
    endfunction

    function automatic result_t fadd(input logic [63:0] x, input logic [63:0] y);
        logic               xz, yz, xi, yi;
        logic [63:0]        big, sml;
        logic [10:0]        d;
        logic [55:0]        mb, ms, sh, n;
        logic [56:0]        sum;
        logic [5:0]         lz;
        logic signed [13:0] e;
        xz = x[62:52] == 11'd0;
        yz = y[62:52] == 11'd0;
        xi = x[62:52] == 11'h7FF;
        yi = y[62:52] == 11'h7FF;
        if (is_nan(x) || is_nan(y))         return mk(1'b1, QNAN);
        if (xi && yi && (x[63] != y[63]))   return mk(1'b1, QNAN);
        if (xi)                             return mk(1'b1, {x[63], 11'h7FF, 52'd0});
        if (yi)                             return mk(1'b1, {y[63], 11'h7FF, 52'd0});
        if (xz && yz)                       return mk(1'b0, {x[63] & y[63], 63'd0});
        if (xz)                             return mk(1'b0, y);
        if (yz)                             return mk(1'b0, x);
        if (x[62:0] >= y[62:0]) begin
            big = x;
            sml = y;
        end else begin
            big = y;
            sml = x;
        end
        d  = big[62:52] - sml[62:52];
        mb = {1'b1, big[51:0], 3'd0};
        ms = {1'b1, sml[51:0], 3'd0};
        // Everything shifted past the round bit collapses into the sticky bit.
        if (d >= 11'd56) sh = 56'd1;
        else             sh = (ms >> d) | {55'd0, |(ms & ((56'd1 << d) - 56'd1))};
        e = $signed({3'd0, big[62:52]});
        if (big[63] == sml[63]) begin
            sum = {1'b0, mb} + {1'b0, sh};
            if (sum[56]) begin
                n = {sum[56:2], |sum[1:0]};
                e = e + 14'sd1;
            end else begin
                n = sum[55:0];
            end
        end else begin
            n = mb - sh;
            if (n == 56'd0) return mk(1'b0, 64'd0);
            lz = clz56(n);
            n  = n << lz;
            e  = e - $signed({8'd0, lz});
        end
        return round_pack(big[63], e, n);
    endfunction

    function automatic result_t fmul(input logic [63:0] x, input logic [63:0] y);
        logic               s, xz, yz, xi, yi;
        logic [105:0]       p;
        logic [55:0]        n;
        logic signed [13:0] e;
        s  = x[63] ^ y[63];
        xz = x[62:52] == 11'd0;
        yz = y[62:52] == 11'd0;
        xi = x[62:52] == 11'h7FF;
        yi = y[62:52] == 11'h7FF;
        if (is_nan(x) || is_nan(y))         return mk(1'b1, QNAN);
        if ((xi && yz) || (yi && xz))       return mk(1'b1, QNAN);
        if (xi || yi)                       return mk(1'b1, {s, 11'h7FF, 52'd0});
        if (xz || yz)                       return mk(1'b0, {s, 63'd0});
        p = {53'd0, 1'b1, x[51:0]} * {53'd0, 1'b1, y[51:0]};
        e = $signed({3'd0, x[62:52]}) + $signed({3'd0, y[62:52]}) - 14'sd1023;
        if (p[105]) begin
            n = {p[105:51], |p[50:0]};
            e = e + 14'sd1;
        end else begin
            n = {p[104:50], |p[49:0]};
        end
        return round_pack(s, e, n);
    endfunction

    logic [STAGES:1]        vld_pipe;
    logic [63:0]            a_q, b_q;
    result_t                comp;
    result_t [STAGES:2]     res_pipe;

    // Stage 1 registers operands, the arithmetic sits between stage 1 and 2, the rest is delay.
    always_comb begin
        comp = '0;
        if (OP == 2) comp = fmul(a_q, b_q);
        else         comp = fadd(a_q, {b_q[63] ^ (OP == 1), b_q[62:0]});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_pipe <= '0;
        end else begin
            vld_pipe    <= {vld_pipe[STAGES-1:1], up_valid};
            a_q         <= a;
            b_q         <= b;
            res_pipe[2] <= comp;
            for (int s = 3; s <= STAGES; s++)
                res_pipe[s] <= res_pipe[s-1];
        end
    end

    assign res        = res_pipe[STAGES].val;
    assign error      = res_pipe[STAGES].err;
    assign down_valid = vld_pipe[STAGES];
    assign busy       = 1'b0;

endmodule

// File: tb/tb_f_add_sub_mult.sv
// Bench for f_add_sub_mult: add, sub and mul instances share operands; a real-arithmetic model
// plus directed constants give every expected value.
module tb_f_add_sub_mult;
    localparam int LATENCY = 3;
`ifdef F_ARITH_OUT_REG_EN
    localparam int LAT = LATENCY + 1;
`else
    localparam int LAT = LATENCY;
`endif
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] ONE  = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] TWO  = 64'h4000_0000_0000_0000;
    localparam logic [63:0] THR  = 64'h4008_0000_0000_0000;
    localparam logic [63:0] INF  = 64'h7FF0_0000_0000_0000;

    logic        clk, rst, up_valid;
    logic [63:0] a, b;
    logic [63:0] res_o [3];
    logic        dv_o [3];
    logic        busy_o [3];
    logic        err_o [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        f_add_sub_mult #(.FLEN(64), .OP(g), .LATENCY(LATENCY)) u_dut (
            .clk(clk), .rst(rst), .a(a), .b(b), .up_valid(up_valid),
            .res(res_o[g]), .down_valid(dv_o[g]), .busy(busy_o[g]), .error(err_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        int              due;
        logic [2:0][64:0] e;
        logic            hk;
        logic [1:0]      kop;
        logic [64:0]     k;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0, vecs = 0, checks = 0, miscompares = 0;

    // Reference: host double arithmetic is IEEE RNE; map NaN to canonical, flush tiny results.
    function automatic logic [64:0] model(input int op, input logic [63:0] x, input logic [63:0] y);
        real         rx, ry, rr;
        logic [63:0] rb;
        rx = $bitstoreal(x);
        ry = $bitstoreal(y);
        case (op)
            0:       rr = rx + ry;
            1:       rr = rx - ry;
            default: rr = rx * ry;
        endcase
        rb = $realtobits(rr);
        if (rb[62:52] == 11'h7FF) return (rb[51:0] != 52'd0) ? {1'b1, QNAN} : {1'b1, rb};
        if (rb[62:52] == 11'd0)   return {1'b0, rb[63], 63'd0};
        return {1'b0, rb};
    endfunction

    function automatic logic [63:0] rnd_fp(input int ex);
        logic [63:0] r;
        r = {$urandom, $urandom};
        r[62:52] = 11'(ex);
        return r;
    endfunction

    task automatic check_outputs();
        exp_t e;
        logic ev;
        ev = (sb.size() != 0) && (sb[0].due == cyc);
        for (int i = 0; i < 3; i++) begin
            checks++;
            assert (dv_o[i] === ev) else begin
                miscompares++;
                $error("FAIL down_valid op%0d cyc%0d: got %b expected %b", i, cyc, dv_o[i], ev);
            end
            checks++;
            assert (busy_o[i] === 1'b0) else begin
                miscompares++;
                $error("FAIL busy op%0d cyc%0d: got %b expected 0", i, cyc, busy_o[i]);
            end
        end
        if (ev) begin
            e = sb.pop_front();
            for (int i = 0; i < 3; i++) begin
                checks++;
                assert ({err_o[i], res_o[i]} === e.e[i]) else begin
                    miscompares++;
                    $error("FAIL model op%0d cyc%0d: got err=%b res=%h expected err=%b res=%h",
                           i, cyc, err_o[i], res_o[i], e.e[i][64], e.e[i][63:0]);
                end
            end
            if (e.hk) begin
                checks++;
                assert ({err_o[e.kop], res_o[e.kop]} === e.k) else begin
                    miscompares++;
                    $error("FAIL directed op%0d cyc%0d: got err=%b res=%h expected err=%b res=%h",
                           e.kop, cyc, err_o[e.kop], res_o[e.kop], e.k[64], e.k[63:0]);
                end
            end
        end
    endtask

    task automatic check_reset_state();
        for (int i = 0; i < 3; i++) begin
            checks++;
            assert (res_o[i] === 64'd0) else begin
                miscompares++;
                $error("FAIL reset_res op%0d: got %h expected 0", i, res_o[i]);
            end
            checks++;
            assert (err_o[i] === 1'b0) else begin
                miscompares++;
                $error("FAIL reset_err op%0d: got %b expected 0", i, err_o[i]);
            end
        end
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic keep, input logic [63:0] av, input logic [63:0] bv,
                         input logic hk, input int kop, input logic [64:0] k);
        exp_t e;
        @(negedge clk);
        check_outputs();
        a = av;
        b = bv;
        up_valid = v;
        if (v) begin
            vecs++;
            if (keep) begin
                e.due = cyc + LAT;
                for (int i = 0; i < 3; i++) e.e[i] = model(i, av, bv);
                e.hk  = hk;
                e.kop = 2'(kop);
                e.k   = k;
                sb.push_back(e);
            end
        end
        cyc++;
    endtask

    task automatic go(input logic [63:0] av, input logic [63:0] bv);
        drive(1'b1, 1'b1, av, bv, 1'b0, 0, 65'd0);
    endtask

    task automatic go_k(input logic [63:0] av, input logic [63:0] bv, input int op, input logic [64:0] k);
        drive(1'b1, 1'b1, av, bv, 1'b1, op, k);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 0, 65'd0);
    endtask

    int          ea, eb;
    logic [63:0] av, bv;

    initial begin
        rst = 1'b1; up_valid = 1'b0; a = '0; b = '0;
        @(negedge clk);
        check_reset_state();
        @(negedge clk);
        rst = 1'b0;

        // Directed cases, each isolated so the single-pulse timing is visible.
        go_k(ONE, TWO, 0, {1'b0, THR});                                        idle(LAT);
        go_k(TWO, THR, 2, {1'b0, 64'h4018_0000_0000_0000});                    idle(LAT);
        go_k(64'h3FD3_3333_3333_3333, ONE, 2, {1'b0, 64'h3FD3_3333_3333_3333}); idle(LAT);
        go_k(THR, ONE, 1, {1'b0, TWO});                                        idle(LAT);
        go_k(ONE, ONE, 1, {1'b0, 64'd0});                                      idle(LAT);
        go_k(64'd0, INF, 2, {1'b1, QNAN});                                     idle(LAT);
        go_k(64'h7FE0_0000_0000_0000, 64'h7FE0_0000_0000_0000, 0, {1'b1, INF}); idle(LAT);
        go_k(64'h7FF0_0000_0000_0001, ONE, 0, {1'b1, QNAN});                   idle(LAT);
        go_k(INF, INF, 1, {1'b1, QNAN});                                       idle(LAT);
        go_k(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, {1'b0, 64'h8000_0000_0000_0000});
        go_k(ONE, 64'h3C30_0000_0000_0000, 0, {1'b0, ONE});
        go_k(ONE, 64'h3CA0_0000_0000_0000, 0, {1'b0, ONE});
        go(64'h3FF0_0000_0000_0001, 64'h3CA0_0000_0000_0000);
        go(64'hC008_0000_0000_0000, 64'h4008_0000_0000_0001);
        idle(LAT + 1);

        // Reset with two results in flight: neither may emerge.
        drive(1'b1, 1'b0, ONE, TWO, 1'b0, 0, 65'd0);
        drive(1'b1, 1'b0, THR, TWO, 1'b0, 0, 65'd0);
        @(negedge clk);
        check_outputs();
        rst = 1'b1; up_valid = 1'b0; cyc++;
        @(negedge clk);
        check_reset_state();
        rst = 1'b0; cyc++;
        idle(LAT + 2);
        go_k(ONE, TWO, 0, {1'b0, THR});
        idle(LAT + 1);

        // Back-to-back random normals.
        for (int i = 0; i < 100; i++) begin
            ea = 923 + int'($urandom_range(0, 200));
            case (i % 4)
                0:       eb = ea;
                1:       eb = ea + int'($urandom_range(0, 4)) - 2;
                2:       eb = 923 + int'($urandom_range(0, 200));
                default: eb = ea - int'($urandom_range(50, 60));
            endcase
            av = rnd_fp(ea);
            bv = rnd_fp(eb);
            if (i % 5 == 0) bv = av ^ {$urandom_range(0, 1) == 1, 55'd0, 8'($urandom)};
            go(av, bv);
        end
        idle(LAT + 2);

        $display("%0d checks made", checks);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
